// File: rtl/control_74hc595d_pkg.sv
// Shared types and defaults for the 74HC595 chain driver.
// Holds the frame FSM state encoding.
package control_74hc595d_pkg;

  localparam int DATA_W_DEF  = 16;
  localparam int LATCH_W_DEF = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_LATCH = 2'd3
  } state_e;

endpackage

// File: rtl/control_74hc595d_piso.sv
// Parallel-load, serial-out register with a registered serial bit.
// Load presents the first bit at once; the rest follow one per shift.
module piso_shift_reg #(
  parameter int W         = 16,
  parameter int MSB_FIRST = 1
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [W-1:0] din_i,
  output logic         sout_o
);

  logic [W-1:0] sreg_q;
  logic         sout_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sreg_q <= '0;
      sout_q <= 1'b0;
    end else if (load_i) begin
      if (MSB_FIRST != 0) begin
        sout_q <= din_i[W-1];
        sreg_q <= din_i << 1;
      end else begin
        sout_q <= din_i[0];
        sreg_q <= din_i >> 1;
      end
    end else if (shift_i) begin
      if (MSB_FIRST != 0) begin
        sout_q <= sreg_q[W-1];
        sreg_q <= sreg_q << 1;
      end else begin
        sout_q <= sreg_q[0];
        sreg_q <= sreg_q >> 1;
      end
    end else begin
      // Serial line idles low outside the shift window
      sout_q <= 1'b0;
    end
  end

  assign sout_o = sout_q;

endmodule

// File: rtl/control_74hc595d.sv
// Free-running frame engine: LOAD, SHIFT DATA_W bits, LATCH pulse.
// Outputs are registered so SER/RCLK are glitch-free.
module control_74hc595d
  import control_74hc595d_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int LATCH_W   = LATCH_W_DEF,
  parameter int MSB_FIRST = 1
) (
  input  logic              s_clk,
  input  logic              s_reset,
  input  logic [DATA_W-1:0] data_in,
  output logic              data_out,
  output logic              latch_out
);

  localparam int CW = $clog2(DATA_W + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    lcnt_q, lcnt_d;
  logic          latch_q, latch_d;
  logic          load, shift;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lcnt_d  = lcnt_q;
    latch_d = 1'b0;
    load    = 1'b0;
    shift   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        load    = 1'b1;
        cnt_d   = '0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(DATA_W - 1)) begin
          state_d = ST_LATCH;
          lcnt_d  = '0;
          latch_d = 1'b1;
        end else begin
          shift = 1'b1;
        end
      end
      ST_LATCH: begin
        lcnt_d = lcnt_q + 1'b1;
        if (lcnt_q == 4'(LATCH_W - 1)) begin
          state_d = ST_LOAD;
        end else begin
          latch_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge s_clk) begin
    if (!s_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      lcnt_q  <= '0;
      latch_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lcnt_q  <= lcnt_d;
      latch_q <= latch_d;
    end
  end

  piso_shift_reg #(
    .W         (DATA_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_piso (
    .clk_i   (s_clk),
    .rst_n_i (s_reset),
    .load_i  (load),
    .shift_i (shift),
    .din_i   (data_in),
    .sout_o  (data_out)
  );

  assign latch_out = latch_q;

endmodule

// File: tb/tb_control_74hc595d.sv
// Bench for control_74hc595d: default instance plus an LSB-first,
// 3-cycle-latch instance, checked cycle by cycle against frame tables.
module tb_control_74hc595d;

  typedef struct {
    logic [15:0] din;
    logic [15:0] stream;
  } vec_t;

  typedef struct {
    logic d;
    logic l;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic [15:0] din_a, din_b;
  logic        dout_a, lat_a, dout_b, lat_b;

  vec_t tbl [10];
  exp_t q   [$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  control_74hc595d dut_a (
    .s_clk     (clk),
    .s_reset   (rst_a),
    .data_in   (din_a),
    .data_out  (dout_a),
    .latch_out (lat_a)
  );

  control_74hc595d #(
    .DATA_W    (16),
    .LATCH_W   (3),
    .MSB_FIRST (0)
  ) dut_b (
    .s_clk     (clk),
    .s_reset   (rst_b),
    .data_in   (din_b),
    .data_out  (dout_b),
    .latch_out (lat_b)
  );

  task automatic push(input logic d, input logic l);
    exp_t e;
    e.d = d;
    e.l = l;
    q.push_back(e);
  endtask

  task automatic check(input int sel, input string tag, input int cyc);
    exp_t e;
    logic ad, al;
    ad = (sel == 0) ? dout_a : dout_b;
    al = (sel == 0) ? lat_a : lat_b;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL %s cyc %0d: scoreboard empty, got d=%0b l=%0b",
               tag, cyc, ad, al);
    end else begin
      e = q.pop_front();
      if (ad !== e.d || al !== e.l) begin
        errors++;
        $display("FAIL %s cyc %0d: data_out=%0b latch_out=%0b expected %0b %0b",
                 tag, cyc, ad, al, e.d, e.l);
      end
    end
  endtask

  // Called at a negedge just before the LOAD cycle of frame lo.
  task automatic run_tbl(input int sel, input int lo, input int hi,
                         input int lw);
    if (sel == 0) din_a = tbl[lo].din;
    else          din_b = tbl[lo].din;
    for (int k = lo; k <= hi; k++) begin
      for (int c = 0; c < 17 + lw; c++) begin
        if (c == 0)       push(1'b0, 1'b0);
        else if (c <= 16) push(tbl[k].stream[16 - c], 1'b0);
        else              push(1'b0, 1'b1);
        @(negedge clk);
        check(sel, $sformatf("frame%0d", k), c);
        if (c == 6 && k < hi) begin
          if (sel == 0) din_a = tbl[k + 1].din;
          else          din_b = tbl[k + 1].din;
        end
      end
    end
  endtask

  initial begin
    // stream: first emitted bit is the literal's MSB
    tbl[0] = '{16'h1234, 16'b0001_0010_0011_0100};
    tbl[1] = '{16'h5678, 16'b0101_0110_0111_1000};
    tbl[2] = '{16'hFFFF, 16'b1111_1111_1111_1111};
    tbl[3] = '{16'hFFFF, 16'b1111_1111_1111_1111};
    tbl[4] = '{16'h0000, 16'b0000_0000_0000_0000};
    tbl[5] = '{16'hA5C3, 16'b1010_0101_1100_0011};
    tbl[6] = '{16'hFFFF, 16'b1111_1111_1111_1111};
    tbl[7] = '{16'h0001, 16'b1000_0000_0000_0000};
    tbl[8] = '{16'h8001, 16'b1000_0000_0000_0001};
    tbl[9] = '{16'h00F0, 16'b0000_1111_0000_0000};

    rst_a = 1'b0;
    rst_b = 1'b0;
    din_a = 16'h1234;
    din_b = 16'h0001;
    @(negedge clk);
    @(negedge clk);
    push(1'b0, 1'b0);
    check(0, "reset_a", 0);
    rst_a = 1'b1;

    run_tbl(0, 0, 5, 1);

    // Abort a frame at SHIFT bit 7
    din_a = 16'hFFFF;
    for (int c = 0; c <= 8; c++) begin
      push(c != 0, 1'b0);
      @(negedge clk);
      check(0, "pre_abort", c);
    end
    rst_a = 1'b0;
    push(1'b0, 1'b0);
    @(negedge clk);
    check(0, "abort", 0);
    rst_a = 1'b1;
    run_tbl(0, 6, 6, 1);

    push(1'b0, 1'b0);
    check(1, "reset_b", 0);
    rst_b = 1'b1;
    run_tbl(1, 7, 9, 3);

    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL leftover: %0d entries, expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_74hc595d.md
CONTROL_74HC595D -- requirements
Module: control_74hc595d

Interface
REQ-001 Parameter DATA_W, default 16, number of bits serialized per frame.
REQ-002 Parameter LATCH_W, default 1, number of cycles latch_out is held high per frame (legal range 1..15).
REQ-003 Parameter MSB_FIRST, default 1, 1 = bit DATA_W-1 shifted first, 0 = bit 0 first.
REQ-004 s_clk  input  1  single system clock; all state updates on rising edge.
REQ-005 s_reset  input  1  synchronous, active-low reset (0 = reset, sampled on s_clk rising edge).
REQ-006 data_in  input  DATA_W  parallel word to be shifted out to the 74HC595 chain.
REQ-007 data_out  output  1  serial data to the 74HC595 SER pin, registered.
REQ-008 latch_out  output  1  storage-register clock to the 74HC595 RCLK pin, registered, active-high.

Function
REQ-009 The block SHALL run a free-running FSM with states IDLE, LOAD, SHIFT, LATCH.
REQ-010 IDLE SHALL last exactly one cycle after reset release, then go to LOAD.
REQ-011 LOAD (1 cycle) SHALL snapshot data_in into an internal DATA_W-bit shift register, clear the bit counter, and go to SHIFT.
REQ-012 SHIFT SHALL last exactly DATA_W cycles; in cycle i (0..DATA_W-1) data_out SHALL equal snapshot bit DATA_W-1-i (MSB_FIRST=1) or bit i (MSB_FIRST=0).
REQ-013 data_out SHALL be stable for a full s_clk period per bit; the 74HC595 SRCLK is generated outside this block from inverted s_clk, so each bit is sampled mid-period.
REQ-014 After the last SHIFT cycle the FSM SHALL enter LATCH, holding latch_out=1 for exactly LATCH_W cycles, then return to LOAD.
REQ-015 latch_out SHALL be 0 in every state other than LATCH; data_out SHALL be 0 in IDLE, LOAD, LATCH.
REQ-016 Frame period SHALL be 1 + DATA_W + LATCH_W cycles (18 at defaults), repeating continuously.
REQ-017 Changes of data_in outside the LOAD cycle SHALL NOT affect the frame in progress; the new value appears in the next frame.
REQ-018 Bit counter SHALL be $clog2(DATA_W+1) bits wide and SHALL NOT wrap inside a frame.
REQ-019 Any unreachable state encoding SHALL return to IDLE on the next edge.

Reset
REQ-020 While s_reset=0 at a rising edge, the block SHALL set state=IDLE, data_out=0, latch_out=0, shift register=0, counters=0.
REQ-021 Reset asserted mid-SHIFT or mid-LATCH SHALL abort the frame with no latch pulse; after release the block restarts from IDLE.

Structure
REQ-022 A package control_74hc595d_pkg SHALL hold the FSM state enum and the default DATA_W/LATCH_W constants.
REQ-023 One sub-module piso_shift_reg (parallel-load, serial-out, MSB_FIRST-selectable) is natural; the FSM and counters stay in the top.

Verification
REQ-024 Reset held 1 cycle, data_in=16'h1234 -> after release: 1 IDLE, 1 LOAD, data_out = 0001_0010_0011_0100 over 16 cycles, then latch_out=1 for 1 cycle.
REQ-025 data_in changed to 16'h5678 during SHIFT of the 0x1234 frame -> current frame still emits 0x1234; next frame emits 0101_0110_0111_1000.
REQ-026 Steady data_in=16'hFFFF -> latch_out pulses every 18 cycles exactly; data_out=1 for all 16 SHIFT cycles, 0 otherwise.
REQ-027 s_reset driven 0 during SHIFT bit 7 -> next edge data_out=0, latch_out=0; no latch pulse until a full new frame completes.
REQ-028 MSB_FIRST=0, LATCH_W=3, data_in=16'h0001 -> data_out=1 in first SHIFT cycle only, latch_out high 3 cycles, period 20.
